// File: rtl/ex_mem_elastic_pkg.sv
// Shared constants for the EX->MEM boundary: NOP bubble encodings and the
// packed payload width helper used by the elastic buffer and its bench.
package ex_mem_elastic_pkg;

  localparam logic [7:0]  EXE_NOP_OP = 8'h00;
  localparam logic [2:0]  MEM_NOP    = 3'b000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // Entry = {rd, wreg, wdata, memaddr, pc, reg2, aluop, sel, we, load_sign}
  function automatic int payload_w(input int data_w, input int regaddr_w,
                                   input int aluop_w, input int sel_w);
    return regaddr_w + 1 + (4 * data_w) + aluop_w + sel_w + 2;
  endfunction

endpackage

// File: rtl/ex_mem_elastic_ctrl.sv
// Elastic FIFO control: occupancy count, wrapping pointers, handshake flags
// and flush. Carries no payload so it can serve any pipeline boundary.
module elastic_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic [IDX_W-1:0] wr_ptr,
  output logic [IDX_W-1:0] rd_ptr,
  output logic [2:0]       occupancy
);

  logic [2:0]       count_r;
  logic [IDX_W-1:0] wr_ptr_r;
  logic [IDX_W-1:0] rd_ptr_r;
  logic             pop_s;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + IDX_W'(1);
    end
  endfunction

  // A single entry must forward ready to sustain one transfer per cycle;
  // deeper buffers decouple ready from the consumer entirely.
  generate
    if (DEPTH == 1) begin : g_pass
      assign in_ready = (count_r == 3'd0) | out_ready;
    end else begin : g_elastic
      assign in_ready = (count_r < 3'(DEPTH));
    end
  endgenerate

  assign out_valid = (count_r != 3'd0);
  assign push      = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign wr_ptr    = wr_ptr_r;
  assign rd_ptr    = rd_ptr_r;
  assign occupancy = count_r;

  // Count and pointer update; flush outranks both push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= 3'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      count_r  <= 3'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_elastic.sv
// EX->MEM pipeline boundary as a DEPTH-entry elastic buffer; the head entry
// is masked to a NOP bubble whenever nothing valid is held.
module ex_mem_elastic
  import ex_mem_elastic_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int SEL_W     = 3,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REGADDR_W-1:0] in_rd,
  input  logic                 in_wreg,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic [DATA_W-1:0]    in_memaddr,
  input  logic [DATA_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]    in_reg2,
  input  logic [ALUOP_W-1:0]   in_aluop,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_we,
  input  logic                 in_load_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REGADDR_W-1:0] out_rd,
  output logic                 out_wreg,
  output logic [DATA_W-1:0]    out_wdata,
  output logic [DATA_W-1:0]    out_memaddr,
  output logic [DATA_W-1:0]    out_pc,
  output logic [DATA_W-1:0]    out_reg2,
  output logic [ALUOP_W-1:0]   out_aluop,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_we,
  output logic                 out_load_sign,
  output logic [2:0]           occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAY_W = payload_w(DATA_W, REGADDR_W, ALUOP_W, SEL_W);
  localparam logic [PAY_W-1:0] NOP_PAY = {
    REGADDR_W'(NOPRegAddr), 1'b0,
    DATA_W'(ZeroWord), DATA_W'(ZeroWord), DATA_W'(ZeroWord), DATA_W'(ZeroWord),
    ALUOP_W'(EXE_NOP_OP), SEL_W'(MEM_NOP), 1'b0, 1'b0
  };

  logic [PAY_W-1:0] mem_r [2**IDX_W];
  logic [PAY_W-1:0] in_pay_s;
  logic [PAY_W-1:0] head_s;
  logic             push_s;
  logic [IDX_W-1:0] wr_ptr_s;
  logic [IDX_W-1:0] rd_ptr_s;

  assign in_pay_s = {in_rd, in_wreg, in_wdata, in_memaddr, in_pc, in_reg2,
                     in_aluop, in_sel, in_we, in_load_sign};

  elastic_fifo_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push_s),
    .wr_ptr    (wr_ptr_s),
    .rd_ptr    (rd_ptr_s),
    .occupancy (occupancy)
  );

  // Entry storage; pops and flushes leave contents in place
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_s] <= in_pay_s;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Head selection with bubble masking so MEM never sees stale payload
  always_comb begin
    head_s = NOP_PAY;
    if (out_valid) begin
      head_s = mem_r[rd_ptr_s];
    end else begin
      head_s = NOP_PAY;
    end
  end

  assign {out_rd, out_wreg, out_wdata, out_memaddr, out_pc, out_reg2,
          out_aluop, out_sel, out_we, out_load_sign} = head_s;

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Drives a DEPTH=2 and a DEPTH=1 buffer from shared inputs and checks both
// against per-instance queue models, with directed scenarios then random traffic.
module tb_ex_mem_elastic;
  import ex_mem_elastic_pkg::*;

  localparam int PW = 147;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [4:0]  in_rd;
  logic        in_wreg, in_we, in_load_sign;
  logic [31:0] in_wdata, in_memaddr, in_pc, in_reg2;
  logic [7:0]  in_aluop;
  logic [2:0]  in_sel;

  logic        in_ready_a, out_valid_a, out_wreg_a, out_we_a, out_load_sign_a;
  logic [4:0]  out_rd_a;
  logic [31:0] out_wdata_a, out_memaddr_a, out_pc_a, out_reg2_a;
  logic [7:0]  out_aluop_a;
  logic [2:0]  out_sel_a, occupancy_a;
  logic        in_ready_b, out_valid_b, out_wreg_b, out_we_b, out_load_sign_b;
  logic [4:0]  out_rd_b;
  logic [31:0] out_wdata_b, out_memaddr_b, out_pc_b, out_reg2_b;
  logic [7:0]  out_aluop_b;
  logic [2:0]  out_sel_b, occupancy_b;

  logic [PW-1:0] pay_o [2];
  logic          rdy_o [2];
  logic          vld_o [2];
  logic [2:0]    occ_o [2];

  logic [PW-1:0] q [2][$];
  int            dep [2] = '{2, 1};
  int            n_pass = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  ex_mem_elastic #(.DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_rd(in_rd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_memaddr(in_memaddr),
    .in_pc(in_pc), .in_reg2(in_reg2), .in_aluop(in_aluop), .in_sel(in_sel),
    .in_we(in_we), .in_load_sign(in_load_sign), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_rd(out_rd_a), .out_wreg(out_wreg_a),
    .out_wdata(out_wdata_a), .out_memaddr(out_memaddr_a), .out_pc(out_pc_a),
    .out_reg2(out_reg2_a), .out_aluop(out_aluop_a), .out_sel(out_sel_a),
    .out_we(out_we_a), .out_load_sign(out_load_sign_a), .occupancy(occupancy_a));

  ex_mem_elastic #(.DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_rd(in_rd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_memaddr(in_memaddr),
    .in_pc(in_pc), .in_reg2(in_reg2), .in_aluop(in_aluop), .in_sel(in_sel),
    .in_we(in_we), .in_load_sign(in_load_sign), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_rd(out_rd_b), .out_wreg(out_wreg_b),
    .out_wdata(out_wdata_b), .out_memaddr(out_memaddr_b), .out_pc(out_pc_b),
    .out_reg2(out_reg2_b), .out_aluop(out_aluop_b), .out_sel(out_sel_b),
    .out_we(out_we_b), .out_load_sign(out_load_sign_b), .occupancy(occupancy_b));

  assign pay_o[0] = {out_rd_a, out_wreg_a, out_wdata_a, out_memaddr_a, out_pc_a,
                     out_reg2_a, out_aluop_a, out_sel_a, out_we_a, out_load_sign_a};
  assign pay_o[1] = {out_rd_b, out_wreg_b, out_wdata_b, out_memaddr_b, out_pc_b,
                     out_reg2_b, out_aluop_b, out_sel_b, out_we_b, out_load_sign_b};
  assign rdy_o[0] = in_ready_a;
  assign rdy_o[1] = in_ready_b;
  assign vld_o[0] = out_valid_a;
  assign vld_o[1] = out_valid_b;
  assign occ_o[0] = occupancy_a;
  assign occ_o[1] = occupancy_b;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [PW-1:0] mk(input logic [4:0] rd, input logic wreg,
                                       input logic [31:0] wdata, input logic [31:0] pc,
                                       input logic we);
    return {rd, wreg, wdata, pc + 32'd100, pc, ~wdata, 8'h21, 3'd2, we, 1'b1};
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic logic model_ready(input int d, input logic ordy);
    if (dep[d] >= 2) return (q[d].size() < dep[d]);
    else return (q[d].size() == 0) || ordy;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_in_ready", d), 160'(rdy_o[d]), 160'(model_ready(d, out_ready)));
      chk($sformatf("d%0d_out_valid", d), 160'(vld_o[d]), 160'(q[d].size() != 0));
      chk($sformatf("d%0d_occupancy", d), 160'(occ_o[d]), 160'(q[d].size()));
      chk($sformatf("d%0d_payload", d), 160'(pay_o[d]),
          (q[d].size() != 0) ? 160'(q[d][0]) : 160'd0);
    end
  endtask

  // One clock of stimulus: drive at negedge, check, then advance the models
  task automatic step(input logic v, input logic [PW-1:0] p, input logic ordy,
                      input logic fl);
    logic rdy;
    in_valid = v;
    out_ready = ordy;
    flush = fl;
    {in_rd, in_wreg, in_wdata, in_memaddr, in_pc, in_reg2,
     in_aluop, in_sel, in_we, in_load_sign} = p;
    #1;
    check_all();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      rdy = model_ready(d, ordy);
      if (fl) begin
        q[d].delete();
      end else begin
        if (q[d].size() != 0 && ordy) void'(q[d].pop_front());
        if (v && rdy) q[d].push_back(p);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_rd, in_wreg, in_wdata, in_memaddr, in_pc, in_reg2,
     in_aluop, in_sel, in_we, in_load_sign} = '0;
    #1;
    check_all();
    chk("rst_aluop", 160'(out_aluop_a), 160'(EXE_NOP_OP));
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of a cycle with two entries held
    step(1'b1, mk(5'd1, 1'b1, 32'h11, 32'h0F00, 1'b0), 1'b0, 1'b0);
    step(1'b1, mk(5'd2, 1'b1, 32'h22, 32'h0F04, 1'b0), 1'b0, 1'b0);
    chk("pre_rst_occ", 160'(occupancy_a), 160'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 160'(out_valid_a), 160'd0);
    chk("async_rst_rd", 160'(out_rd_a), 160'd0);
    chk("async_rst_aluop", 160'(out_aluop_a), 160'(EXE_NOP_OP));
    chk("async_rst_occ", 160'(occupancy_a), 160'd0);
    q[0].delete();
    q[1].delete();
    @(negedge clk);
    rst = 1'b1;

    // Streaming with the consumer always ready
    for (int k = 0; k < 8; k++)
      step(1'b1, mk(5'(k), 1'b1, 32'(k), 32'h1000 + 32'(4 * k), 1'b0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: third push must wait for space
    step(1'b1, mk(5'd3, 1'b1, 32'h1, 32'h2000, 1'b0), 1'b0, 1'b0);
    step(1'b1, mk(5'd3, 1'b1, 32'h2, 32'h2004, 1'b0), 1'b0, 1'b0);
    step(1'b1, mk(5'd3, 1'b1, 32'h3, 32'h2008, 1'b0), 1'b0, 1'b0);
    #1;
    chk("bp_in_ready", 160'(in_ready_a), 160'd0);
    chk("bp_hold_pc", 160'(out_pc_a), 160'h2000);
    for (int k = 0; k < 4; k++)
      step(1'b1, mk(5'd3, 1'b1, 32'h3, 32'h2008, 1'b0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush colliding with a push
    step(1'b1, mk(5'd4, 1'b1, 32'h4, 32'h2F00, 1'b0), 1'b0, 1'b0);
    step(1'b1, mk(5'd4, 1'b1, 32'h5, 32'h2F04, 1'b0), 1'b0, 1'b0);
    step(1'b1, mk(5'd4, 1'b1, 32'h6, 32'h3000, 1'b0), 1'b0, 1'b1);
    #1;
    chk("flush_valid", 160'(out_valid_a), 160'd0);
    chk("flush_occ", 160'(occupancy_a), 160'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Single-entry pass-through at full rate
    step(1'b1, mk(5'd5, 1'b1, 32'hA5A5A5A5, 32'h4000, 1'b0), 1'b0, 1'b0);
    chk("d1_first", 160'(out_wdata_b), 160'hA5A5A5A5);
    step(1'b1, mk(5'd5, 1'b1, 32'h5A5A5A5A, 32'h4004, 1'b0), 1'b1, 1'b0);
    chk("d1_second", 160'(out_wdata_b), 160'h5A5A5A5A);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Bubble masking after the stored entry is popped
    step(1'b1, mk(5'd7, 1'b1, 32'h77, 32'h5000, 1'b1), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_wreg", 160'(out_wreg_a), 160'd0);
    chk("bubble_we", 160'(out_we_a), 160'd0);
    chk("bubble_rd", 160'(out_rd_a), 160'd0);
    chk("bubble_valid", 160'(out_valid_a), 160'd0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      step(($urandom % 4) != 0, rnd_pay(), ($urandom % 3) != 0, ($urandom % 32) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
